// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB
// and drives datapath enables plus 2-bit mux selects.
// Ports: clk, reset_n (sync, active-low); opcode, bcond, halt_req, mem_ready in;
//        pc_write, i_or_d, mem_read, mem_write, ir_write, alu_src_a, alu_src_b,
//        alu_op, pc_source, mem_to_reg, reg_write, instr_done, is_halted out.
module multicycle_control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       is_halted
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_BR_TAKE, S_PC_INC, S_HALT
    } state_t;

    state_t state, nxt;

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_ecall;
    logic legal;

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_ld    = (opcode == OP_LOAD);
    assign is_st    = (opcode == OP_STORE);
    assign is_br    = (opcode == OP_BR);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_ecall = (opcode == OP_ECALL);
    assign legal    = is_r | is_i | is_ld | is_st | is_br
                    | is_jal | is_jalr | is_ecall;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IF;
        else          state <= nxt;
    end

    always_comb begin
        nxt        = state;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        is_halted  = 1'b0;

        unique case (state)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                if (mem_ready) nxt = S_ID;
            end
            S_ID: begin
                // ALUOut <= PC+4, reused by JAL/JALR link and nops
                alu_src_b = 2'b01;
                if (is_ecall)
                    nxt = halt_req ? S_HALT : S_PC_INC;
                else if (!legal)
                    nxt = HALT_ON_ILLEGAL ? S_HALT : S_PC_INC;
                else
                    nxt = S_EX;
            end
            S_EX: begin
                unique case (1'b1)
                    is_r: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                        nxt       = S_WB;
                    end
                    is_i: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b11;
                        nxt       = S_WB;
                    end
                    is_ld, is_st: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        nxt       = S_MEM;
                    end
                    is_br: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        if (bcond) begin
                            nxt = S_BR_TAKE;
                        end else begin
                            // not taken: PC <= ALUOut (PC+4 from ID)
                            pc_write  = 1'b1;
                            pc_source = 2'b01;
                            nxt       = S_IF;
                        end
                    end
                    is_jal, is_jalr: begin
                        // rd <= old ALUOut (PC+4) while PC <= live target
                        alu_src_a = is_jalr;
                        alu_src_b = 2'b10;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        nxt       = S_IF;
                    end
                    default: nxt = S_PC_INC;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_ld;
                mem_write = !is_ld;
                if (mem_ready) nxt = is_ld ? S_WB : S_PC_INC;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld ? 2'b01 : 2'b00;
                alu_src_b  = 2'b01;
                pc_write   = 1'b1;
                nxt        = S_IF;
            end
            S_BR_TAKE: begin
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                nxt       = S_IF;
            end
            S_PC_INC: begin
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                nxt       = S_IF;
            end
            S_HALT: begin
                is_halted = 1'b1;
            end
        endcase

        // reset masks every output, including a pending memory request
        if (!reset_n) begin
            pc_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_source  = 2'b00;
            mem_to_reg = 2'b00;
            reg_write  = 1'b0;
            is_halted  = 1'b0;
        end
    end

    assign instr_done = pc_write;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multi-cycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and the 2-bit select lines that feed the core's 4:1 operand/PC/writeback muxes.
- Sits directly upstream of those muxes. Consumes the IR opcode, branch condition and memory ready.

Parameters:
HALT_ON_ILLEGAL, 0, 1: unknown opcode enters HALT; 0: unknown opcode is executed as a nop (PC+4)

Ports:
clk  input  1  core clock, all state changes on rising edge
reset_n  input  1  synchronous, active-low reset
opcode  input  7  IR[6:0], stable from the ID state onward
bcond  input  1  branch-compare result from ALU, valid during EX
halt_req  input  1  ECALL halt condition (x17==10), valid in ID
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  load PC
i_or_d  output  1  memory address select: 0 PC, 1 ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load IR
alu_src_a  output  1  0 PC, 1 rs1
alu_src_b  output  2  00 rs2, 01 const 4, 10 imm, 11 reserved
alu_op  output  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
pc_source  output  2  00 live ALU result, 01 ALUOut reg, 1x reserved
mem_to_reg  output  2  00 ALUOut reg, 01 MDR, 1x reserved
reg_write  output  1  register file write
instr_done  output  1  equals pc_write; one pulse per retired instruction
is_halted  output  1  high in HALT

Behaviour:
- States: IF, ID, EX, MEM, WB, BR_TAKE, PC_INC, HALT.
- Reset: on a rising edge with reset_n=0, state<=IF. While reset_n=0 all outputs are 0, overriding the state decode.
- Outputs are combinational from state, opcode, bcond and mem_ready. Any output not listed for a state is 0.
- Supported opcodes: R 0110011, I-arith 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
- IF:
  - Outputs: i_or_d=0, mem_read=1, ir_write=mem_ready.
  - Stays in IF while mem_ready=0; goes to ID on mem_ready=1.
- ID:
  - Outputs: alu_src_a=0, alu_src_b=01, alu_op=00 (ALUOut<=PC+4).
  - ECALL with halt_req=1 -> HALT. ECALL with halt_req=0 -> PC_INC.
  - Illegal opcode -> HALT if HALT_ON_ILLEGAL=1, else PC_INC.
  - All other opcodes -> EX.
- EX:
  - R: a=1, b=00, op=10 -> WB.
  - I-arith: a=1, b=10, op=11 -> WB.
  - LOAD/STORE: a=1, b=10, op=00 -> MEM.
  - BRANCH: a=1, b=00, op=01. If bcond=0: pc_write=1, pc_source=01 (PC+4) -> IF. If bcond=1 -> BR_TAKE.
  - JAL: a=0, b=10, op=00. JALR: a=1, b=10, op=00. Both: reg_write=1, mem_to_reg=00 (old ALUOut = PC+4), pc_write=1, pc_source=00 -> IF.
- BR_TAKE: a=0, b=10, op=00, pc_write=1, pc_source=00 -> IF.
- MEM:
  - Common: i_or_d=1.
  - LOAD: mem_read=1; hold until mem_ready, then -> WB.
  - STORE: mem_write=1; hold until mem_ready, then -> PC_INC.
  - The request stays asserted every waiting cycle.
- WB:
  - Outputs: reg_write=1; mem_to_reg=01 for LOAD, else 00.
  - Simultaneously: a=0, b=01, op=00, pc_write=1, pc_source=00 -> IF.
- PC_INC: a=0, b=01, op=00, pc_write=1, pc_source=00 -> IF.
- HALT: is_halted=1, all other outputs 0. Exited only by reset.
- Invariants:
  - Never assert mem_read and mem_write together.
  - Never assert pc_write twice for one instruction.
  - Reserved select codes are never driven.
- Reset mid-access (any state, including mem_ready pending): the request drops in the same cycle and the next state is IF.

Test Plan:
- R-type ADD, mem_ready always 1 -> IF,ID,EX,WB. reg_write only in WB. pc_write once at cycle 4, pc_source=00, alu_src_b=01.
- LOAD with mem_ready low 2 cycles in MEM -> IF,ID,EX,MEM,MEM,MEM,WB (7 cycles). mem_read=1, i_or_d=1 throughout MEM; mem_to_reg=01 in WB.
- STORE -> IF,ID,EX,MEM,PC_INC. mem_write=1 only in MEM, reg_write never 1.
- BRANCH: bcond=0 -> pc_write in EX with pc_source=01 (3 cycles). bcond=1 -> BR_TAKE, pc_write with alu_src_b=10 (4 cycles).
- JAL then JALR -> each 3 cycles. reg_write=1 and pc_write=1 in EX, mem_to_reg=00. JALR has alu_src_a=1.
- ECALL with halt_req=1 -> HALT after ID: is_halted=1, outputs 0 for 20 cycles. Reset_n=0 in HALT, or in MEM with mem_ready=0 -> outputs 0 immediately, IF after release. Opcode 0000000 with HALT_ON_ILLEGAL=0 -> PC_INC; with HALT_ON_ILLEGAL=1 -> HALT.
